// File: rtl/i2s_rx_deser.sv
// I2S receiver: oversamples BCLK/WCLK/DATA0/DATA1 in the MCLK domain and pushes
// tagged MSB-aligned samples into a small valid/ready FIFO. Optional macro: I2S_RX_FRAME_CHECK_EN.
module i2s_rx_deser #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             MCLK_IN,
  input  logic             RSTN_IN,
  input  logic             BCLK_IN,
  input  logic             WCLK_IN,
  input  logic             DATA0_IN,
  input  logic             DATA1_IN,
  input  logic             READY_IN,
  input  logic             CLR_IN,
  output logic [WIDTH-1:0] SAMPLE_OUT,
  output logic [1:0]       CHAN_OUT,
  output logic             VALID_OUT,
  output logic             OVERRUN_OUT,
  output logic             FRAME_ERR_OUT
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [CW-1:0] CNT_W    = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_TOP  = CW'(WIDTH - 1);
  localparam logic [PW-1:0] FULL_CNT = PW'(FIFO_DEPTH);

  typedef struct packed {
    logic [1:0]       chan;
    logic [WIDTH-1:0] sample;
  } entry_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_LINE0,
    PH_LINE1
  } push_state_e;

  // Synchroniser vectors, packed as {bclk, wclk, data1, data0}
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic       bclk_prev_q, bclk_prev_d;

  logic bclk_s, wclk_s, d0_s, d1_s;
  logic strobe, boundary, commit;

  logic             wclk_lat_q, wclk_lat_d;
  logic             armed_q, armed_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] word0, word1, bit_mask;
  logic [CW-1:0]    word_bits;

  logic [WIDTH-1:0] hold0_q, hold0_d;
  logic [WIDTH-1:0] hold1_q, hold1_d;
  logic             hold_side_q, hold_side_d;
  push_state_e      state_q, state_d;
  logic             push;
  entry_t           push_entry;

  entry_t        fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fifo_cnt;
  logic          fifo_empty, fifo_full, fifo_we, pop;
  entry_t        head;
  logic          overrun_q, overrun_d;

  assign bclk_s = sync2_q[3];
  assign wclk_s = sync2_q[2];
  assign d1_s   = sync2_q[1];
  assign d0_s   = sync2_q[0];

  always_comb begin
    sync1_d     = {BCLK_IN, WCLK_IN, DATA1_IN, DATA0_IN};
    sync2_d     = sync1_q;
    bclk_prev_d = bclk_s;
  end

  assign strobe   = bclk_s & ~bclk_prev_q;
  assign boundary = wclk_s ^ wclk_lat_q;
  assign commit   = strobe & boundary & armed_q;

  // The boundary strobe's bit belongs to the finishing word, so word0/word1 are
  // formed with that bit included before deciding between commit and shift.
  always_comb begin
    wclk_lat_d = wclk_lat_q;
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    bit_mask   = WIDTH'(1) << (CNT_TOP - cnt_q);
    word0      = sh0_q;
    word1      = sh1_q;
    word_bits  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    if (cnt_q < CNT_W) begin
      if (d0_s) word0 = sh0_q | bit_mask;
      if (d1_s) word1 = sh1_q | bit_mask;
    end
    if (strobe) begin
      wclk_lat_d = wclk_s;
      if (boundary) begin
        cnt_d   = '0;
        sh0_d   = '0;
        sh1_d   = '0;
        armed_d = 1'b1;
      end else begin
        cnt_d = word_bits;
        sh0_d = word0;
        sh1_d = word1;
      end
    end
  end

  always_comb begin
    hold0_d     = commit ? word0 : hold0_q;
    hold1_d     = commit ? word1 : hold1_q;
    hold_side_d = commit ? wclk_lat_q : hold_side_q;
  end

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      PH_IDLE: begin
        if (commit) state_d = PH_LINE0;
      end
      PH_LINE0: begin
        push       = 1'b1;
        push_entry = '{chan: {1'b0, hold_side_q}, sample: hold0_q};
        state_d    = PH_LINE1;
      end
      PH_LINE1: begin
        push       = 1'b1;
        push_entry = '{chan: {1'b1, hold_side_q}, sample: hold1_q};
        state_d    = commit ? PH_LINE0 : PH_IDLE;
      end
      default: state_d = PH_IDLE;
    endcase
  end

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign head       = fifo_mem_q[rd_ptr_q[AW-1:0]];

  assign VALID_OUT  = ~fifo_empty;
  assign SAMPLE_OUT = fifo_empty ? '0 : head.sample;
  assign CHAN_OUT   = fifo_empty ? '0 : head.chan;

  // When full, a concurrent pop frees the slot the write lands in
  always_comb begin
    pop       = VALID_OUT & READY_IN;
    fifo_we   = push & (~fifo_full | pop);
    wr_ptr_d  = wr_ptr_q + PW'(fifo_we);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    overrun_d = (push & fifo_full & ~pop) ? 1'b1 : (CLR_IN ? 1'b0 : overrun_q);
  end

  assign OVERRUN_OUT = overrun_q;

  always_ff @(posedge MCLK_IN or negedge RSTN_IN) begin
    if (!RSTN_IN) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      bclk_prev_q <= 1'b0;
      wclk_lat_q  <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      hold0_q     <= '0;
      hold1_q     <= '0;
      hold_side_q <= 1'b0;
      state_q     <= PH_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overrun_q   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      bclk_prev_q <= bclk_prev_d;
      wclk_lat_q  <= wclk_lat_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
      hold_side_q <= hold_side_d;
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overrun_q   <= overrun_d;
      if (fifo_we) fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  logic frame_err_q, frame_err_d;

  always_comb begin
    frame_err_d = (commit && (word_bits < CNT_W)) ? 1'b1 : (CLR_IN ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge MCLK_IN or negedge RSTN_IN) begin
    if (!RSTN_IN) frame_err_q <= 1'b0;
    else          frame_err_q <= frame_err_d;
  end

  assign FRAME_ERR_OUT = frame_err_q;
`else
  assign FRAME_ERR_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Bench for i2s_rx_deser: serial I2S stimulus at BCLK = MCLK/4, half-frame level
// reference model feeding an expected-entry queue checked on every FIFO pop.
module tb_i2s_rx_deser;
  localparam int unsigned W     = 24;
  localparam int unsigned DEPTH = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         bclk  = 1'b0;
  logic         wclk  = 1'b0;
  logic         d0    = 1'b0;
  logic         d1    = 1'b0;
  logic         ready = 1'b0;
  logic         clr   = 1'b0;
  logic [W-1:0] sample;
  logic [1:0]   chan;
  logic         valid, overrun, frame_err;

  i2s_rx_deser #(.WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .MCLK_IN(clk), .RSTN_IN(rst_n), .BCLK_IN(bclk), .WCLK_IN(wclk),
    .DATA0_IN(d0), .DATA1_IN(d1), .READY_IN(ready), .CLR_IN(clr),
    .SAMPLE_OUT(sample), .CHAN_OUT(chan), .VALID_OUT(valid),
    .OVERRUN_OUT(overrun), .FRAME_ERR_OUT(frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] s;
    logic [1:0]   c;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        side;
    int          nbits;
    int          slot;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    bit          ferr;
    bit          clr_after;
  } vec_t;
  vec_t tbl [8];

  // Half-frame model state
  logic         last_side_m, pend_side;
  bit           armed_m, pend_valid_m, pend_ferr_m, exp_ferr_m;
  logic [W-1:0] pend_e0, pend_e1;
  logic         pend_b0, pend_b1;

  bit   rand_ready_en = 0;
  logic ready_main    = 1'b0;

  always @(posedge clk) begin
    #2;
    ready = rand_ready_en ? ($urandom_range(3) != 0) : ready_main;
  end

  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL pop_unexpected: got %h/%b, required no entry", sample, chan);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        tests++;
        if (sample !== e.s || chan !== e.c) begin
          fails++;
          $display("FAIL pop_entry: got %h/%b, required %h/%b", sample, chan, e.s, e.c);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_sample(input logic [31:0] w, input int nb);
    logic [63:0] t;
    t = {32'd0, w} << (64 - nb);
    return t[63 -: W];
  endfunction

  function automatic bit ferr_rule(input bit short_word);
`ifdef I2S_RX_FRAME_CHECK_EN
    return short_word;
`else
    return 1'b0 & short_word;
`endif
  endfunction

  // One BCLK period: data lags WCLK by one slot (I2S one-bit delay)
  task automatic send_period(input logic ws, input logic b0, input logic b1, input bit raise);
    bclk = 1'b0; wclk = ws; d0 = pend_b0; d1 = pend_b1;
    pend_b0 = b0; pend_b1 = b1;
    #20; bclk = 1'b1;
    #20;
    if (raise) ready_main = 1'b1;
  endtask

  task automatic send_half(input logic side, input logic [31:0] w0, input logic [31:0] w1,
                           input int nbits, input int slot, input logic [W-1:0] e0,
                           input logic [W-1:0] e1, input bit ferr, input bit raise);
    logic b0, b1;
    if (side != last_side_m) begin
      if (armed_m && pend_valid_m) begin
        exp_q.push_back('{pend_e0, {1'b0, pend_side}});
        exp_q.push_back('{pend_e1, {1'b1, pend_side}});
        if (pend_ferr_m) exp_ferr_m = 1;
      end
      armed_m = 1;
    end
    last_side_m = side; pend_valid_m = 1; pend_side = side;
    pend_e0 = e0; pend_e1 = e1; pend_ferr_m = ferr;
    for (int k = 0; k < slot; k++) begin
      b0 = (k < nbits) ? w0[nbits-1-k] : 1'b0;
      b1 = (k < nbits) ? w1[nbits-1-k] : 1'b0;
      send_period(side, b0, b1, raise && (k == 0));
    end
  endtask

  task automatic send_word(input logic side, input logic [31:0] w0, input logic [31:0] w1,
                           input int nbits, input int slot, input bit raise);
    send_half(side, w0, w1, nbits, slot, model_sample(w0, nbits), model_sample(w1, nbits),
              ferr_rule(nbits < W), raise);
  endtask

  task automatic prime();
    send_half(1'b0, 32'd0, 32'd0, W, W, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic session_reset();
    rst_n = 1'b0; bclk = 1'b0; wclk = 1'b0; d0 = 1'b0; d1 = 1'b0; clr = 1'b0;
    ready_main = 1'b0; rand_ready_en = 0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    last_side_m = 1'b0; armed_m = 0; pend_valid_m = 0; exp_ferr_m = 0;
    pend_b0 = 1'b0; pend_b1 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    exp_ferr_m = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_left"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
    check({name, "_drain_valid"}, valid, 0);
  endtask

  initial begin
    logic [23:0] base;

    tbl[0] = '{1'b1, 24, 32, 32'hA5A5A5, 32'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A, 0, 0};
    tbl[1] = '{1'b0, 24, 32, 32'h000001, 32'h000001, 24'h000001, 24'h000001, 0, 0};
    tbl[2] = '{1'b1, 24, 32, 32'h800000, 32'h800000, 24'h800000, 24'h800000, 0, 0};
    tbl[3] = '{1'b0, 16, 16, 32'hABCD, 32'h1234, 24'hABCD00, 24'h123400, 1, 0};
    tbl[4] = '{1'b1, 32, 32, 32'h12345678, 32'h87654321, 24'h123456, 24'h876543, 0, 1};
    tbl[5] = '{1'b0, 24, 24, 32'hFFFFFF, 32'h000000, 24'hFFFFFF, 24'h000000, 0, 0};
    tbl[6] = '{1'b1, 8, 16, 32'h81, 32'h7F, 24'h810000, 24'h7F0000, 1, 0};
    tbl[7] = '{1'b0, 24, 26, 32'hC3C3C3, 32'h3C3C3C, 24'hC3C3C3, 24'h3C3C3C, 0, 0};

    // Reset asserted mid-frame with entries sitting in the FIFO
    session_reset();
    prime();
    send_word(1'b1, $urandom, $urandom, 24, 32, 0);
    for (int k = 0; k < 10; k++) send_period(1'b0, 1'b1, 1'b1, 0);
    check("pre_reset_valid", valid, 1);
    rst_n = 1'b0;
    #3;
    check("rst_sample", sample, 0);
    check("rst_chan", chan, 0);
    check("rst_valid", valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);

    // Arming, then table-driven capture
    session_reset();
    prime();
    send_half(tbl[0].side, tbl[0].w0, tbl[0].w1, tbl[0].nbits, tbl[0].slot,
              tbl[0].e0, tbl[0].e1, ferr_rule(tbl[0].ferr), 0);
    check("arm_no_push", valid, 0);
    ready_main = 1'b1;
    for (int i = 1; i < 8; i++) begin
      send_half(tbl[i].side, tbl[i].w0, tbl[i].w1, tbl[i].nbits, tbl[i].slot,
                tbl[i].e0, tbl[i].e1, ferr_rule(tbl[i].ferr), 0);
      check("frame_err", frame_err, exp_ferr_m);
      if (tbl[i].clr_after) begin
        pulse_clr();
        check("frame_err_clr", frame_err, 0);
      end
    end
    send_word(1'b1, 32'd0, 32'd0, 24, 24, 0);
    check("frame_err_final", frame_err, exp_ferr_m);
    drain("table");

    // Backpressure: 3 half frames committed with READY low
    session_reset();
    prime();
    send_word(1'b1, $urandom, $urandom, 24, 24, 0);
    send_word(1'b0, $urandom, $urandom, 24, 24, 0);
    send_word(1'b1, $urandom, $urandom, 24, 24, 0);
    send_word(1'b0, $urandom, $urandom, 24, 24, 0);
    check("bp_valid", valid, 1);
    check("bp_overrun", overrun, 1);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    pulse_clr();
    check("bp_overrun_clr", overrun, 0);
    ready_main = 1'b1;
    send_word(1'b1, $urandom, $urandom, 24, 24, 0);
    drain("bp");

    // Full FIFO: first pop lands in the same cycle as the next push
    session_reset();
    prime();
    send_word(1'b1, $urandom, $urandom, 24, 24, 0);
    send_word(1'b0, $urandom, $urandom, 24, 24, 0);
    send_word(1'b1, $urandom, $urandom, 24, 24, 0);
    check("full_valid", valid, 1);
    check("full_no_overrun", overrun, 0);
    send_word(1'b0, $urandom, $urandom, 24, 24, 1);
    send_word(1'b1, $urandom, $urandom, 24, 24, 0);
    check("pushpop_no_overrun", overrun, 0);
    drain("pushpop");

    // Sawtooth on line 0, random on line 1, random READY
    session_reset();
    rand_ready_en = 1;
    base = 24'($urandom);
    prime();
    send_word(1'b1, $urandom, $urandom, 24, 24, 0);
    for (int f = 0; f < 200; f++) begin
      send_word(1'b0, {8'd0, base + 24'(f)}, $urandom, 24, 24, 0);
      send_word(1'b1, {8'd0, base + 24'(f)}, $urandom, 24, 24, 0);
    end
    send_word(1'b0, 32'd0, 32'd0, 24, 24, 0);
    drain("saw");
    check("saw_overrun", overrun, 0);
    check("saw_frame_err", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
